// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared memory port,
// ALU, register file and immediate extender; stalls on mem_ready and traps on bad opcodes.
`ifndef Ext_ImmI
`define Ext_ImmI 3'b000
`define Ext_ImmS 3'b001
`define Ext_ImmB 3'b010
`define Ext_ImmJ 3'b011
`define Ext_ImmU 3'b100
`endif

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] sel_ext,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_ITP = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   pc_write_c, ir_write_c, mem_write_c, reg_write_c, instr_done_c;

  always_comb begin
    case (op)
      OP_LW, OP_ITP: sel_ext = `Ext_ImmI;
      OP_SW:         sel_ext = `Ext_ImmS;
      OP_BEQ:        sel_ext = `Ext_ImmB;
      OP_JAL:        sel_ext = `Ext_ImmJ;
      OP_LUI:        sel_ext = `Ext_ImmU;
      default:       sel_ext = `Ext_ImmI;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    instr_done_c = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU computes OldPC + imm here so BEQ already has its target in ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_ITP:       state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        pc_write_c   = zero;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target from DECODE) while the ALU forms OldPC + 4 for rd
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        result_src   = 2'b11;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are masked while reset is held so an aborted instruction writes nothing
  assign pc_write   = pc_write_c & rst_n;
  assign ir_write   = ir_write_c & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign instr_done = instr_done_c & rst_n;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output sequences are
// built from the instruction's step list and compared cycle by cycle under random stalls.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [6:0] op;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] sel_ext;

  int n_pass  = 0;
  int n_total = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .sel_ext(sel_ext),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_ITP = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [2:0] X_I = 3'b000, X_S = 3'b001, X_B = 3'b010, X_J = 3'b011, X_U = 3'b100;

  // {pc_write, adr_src, ir_write, mem_write, reg_write, instr_done, result_src, alu_src_a, alu_src_b, alu_op}
  localparam logic [13:0] V_FWAIT  = {6'b000000, 8'b00_00_10_00};
  localparam logic [13:0] V_FETCH  = {6'b101000, 8'b00_00_10_00};
  localparam logic [13:0] V_DECODE = {6'b000000, 8'b00_01_01_00};
  localparam logic [13:0] V_MEMADR = {6'b000000, 8'b00_10_01_00};
  localparam logic [13:0] V_MEMRD  = {6'b010000, 8'b00_00_00_00};
  localparam logic [13:0] V_MEMWB  = {6'b000011, 8'b01_00_00_00};
  localparam logic [13:0] V_MEMWRW = {6'b010100, 8'b00_00_00_00};
  localparam logic [13:0] V_MEMWRD = {6'b010101, 8'b00_00_00_00};
  localparam logic [13:0] V_EXECR  = {6'b000000, 8'b00_10_00_10};
  localparam logic [13:0] V_EXECI  = {6'b000000, 8'b00_10_01_10};
  localparam logic [13:0] V_ALUWB  = {6'b000011, 8'b00_00_00_00};
  localparam logic [13:0] V_JAL    = {6'b100000, 8'b00_01_10_00};
  localparam logic [13:0] V_LUI    = {6'b000011, 8'b11_00_00_00};
  localparam logic [13:0] V_IDLE   = 14'b0;

  typedef struct {
    logic [13:0] v;
    logic        rdy;
    logic        z;
  } step_t;

  step_t q[$];

  function automatic logic [2:0] ext_of(input logic [6:0] o);
    case (o)
      OP_SW:   return X_S;
      OP_BEQ:  return X_B;
      OP_JAL:  return X_J;
      OP_LUI:  return X_U;
      default: return X_I;
    endcase
  endfunction

  function automatic logic legal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_ITP) || (o == OP_R) || (o == OP_SW) ||
           (o == OP_BEQ) || (o == OP_JAL) || (o == OP_LUI);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [13:0] obs_vec();
    return {pc_write, adr_src, ir_write, mem_write, reg_write, instr_done,
            result_src, alu_src_a, alu_src_b, alu_op};
  endfunction

  task automatic push(input logic [13:0] v, input logic rdy, input logic z);
    step_t s;
    s.v = v; s.rdy = rdy; s.z = z;
    q.push_back(s);
  endtask

  // Reference: the cycle-by-cycle step list of one instruction, with fw fetch waits and mw memory waits
  task automatic build(input logic [6:0] o, input int fw, input int mw, input logic z);
    q.delete();
    for (int i = 0; i < fw; i++) push(V_FWAIT, 1'b0, rbit());
    push(V_FETCH, 1'b1, rbit());
    push(V_DECODE, rbit(), rbit());
    case (o)
      OP_LW: begin
        push(V_MEMADR, rbit(), rbit());
        for (int i = 0; i < mw; i++) push(V_MEMRD, 1'b0, rbit());
        push(V_MEMRD, 1'b1, rbit());
        push(V_MEMWB, rbit(), rbit());
      end
      OP_SW: begin
        push(V_MEMADR, rbit(), rbit());
        for (int i = 0; i < mw; i++) push(V_MEMWRW, 1'b0, rbit());
        push(V_MEMWRD, 1'b1, rbit());
      end
      OP_R: begin
        push(V_EXECR, rbit(), rbit());
        push(V_ALUWB, rbit(), rbit());
      end
      OP_ITP: begin
        push(V_EXECI, rbit(), rbit());
        push(V_ALUWB, rbit(), rbit());
      end
      OP_BEQ: push({z, 5'b00001, 8'b00_10_00_01}, rbit(), z);
      OP_JAL: begin
        push(V_JAL, rbit(), rbit());
        push(V_ALUWB, rbit(), rbit());
      end
      OP_LUI: push(V_LUI, rbit(), rbit());
      default: ;
    endcase
  endtask

  // Runs ncyc steps of the instruction (0 = all of it); assumes we sit just after a rising edge
  task automatic drive_instr(input logic [6:0] o, input int fw, input int mw, input logic z,
                             input int ncyc);
    int n, dones;
    logic [13:0] ob;
    build(o, fw, mw, z);
    n = (ncyc > 0) ? ncyc : q.size();
    dones = 0;
    for (int i = 0; i < n; i++) begin
      op = o; mem_ready = q[i].rdy; zero = q[i].z;
      @(negedge clk);
      ob = obs_vec();
      n_total++;
      if (ob !== q[i].v)
        $display("FAIL outputs op=%b step %0d: got %b want %b", o, i, ob, q[i].v);
      else n_pass++;
      n_total++;
      if (sel_ext !== ext_of(o))
        $display("FAIL sel_ext op=%b step %0d: got %b want %b", o, i, sel_ext, ext_of(o));
      else n_pass++;
      n_total++;
      if (illegal !== 1'b0) $display("FAIL illegal_clear op=%b step %0d: got %b want 0", o, i, illegal);
      else n_pass++;
      dones += int'(instr_done);
      @(posedge clk); #1;
    end
    if (ncyc == 0) begin
      n_total++;
      if (dones != (legal(o) ? 1 : 0))
        $display("FAIL instr_done_count op=%b: got %0d want %0d", o, dones, legal(o) ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = OP_R; mem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if ({pc_write, ir_write, mem_write, reg_write, instr_done} !== 5'b0)
        $display("FAIL reset_strobes: got %b want 00000",
                 {pc_write, ir_write, mem_write, reg_write, instr_done});
      else n_pass++;
      @(posedge clk); #1;
    end
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs_vec() !== V_FWAIT) $display("FAIL reset_fetch: got %b want %b", obs_vec(), V_FWAIT);
    else n_pass++;
    n_total++;
    if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    drive_instr(OP_R, 0, 0, rbit(), 0);
  endtask

  task automatic test_lw_wait();
    drive_instr(OP_LW, 0, 2, rbit(), 0);
  endtask

  task automatic test_sw_wait();
    drive_instr(OP_SW, 0, 1, rbit(), 0);
  endtask

  task automatic test_beq();
    drive_instr(OP_BEQ, 0, 0, 1'b1, 0);
    drive_instr(OP_BEQ, 0, 0, 1'b0, 0);
  endtask

  task automatic test_jal_lui();
    drive_instr(OP_JAL, 0, 0, rbit(), 0);
    drive_instr(OP_LUI, 0, 0, rbit(), 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops = '{OP_LW, OP_ITP, OP_R, OP_SW, OP_BEQ, OP_JAL, OP_LUI};
    for (int k = 0; k < 40; k++)
      drive_instr(ops[$urandom_range(0, 6)], int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), rbit(), 0);
  endtask

  task automatic test_reset_mid_lw();
    drive_instr(OP_LW, 0, 3, 1'b0, 3);
    mem_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs_vec() !== V_MEMRD) $display("FAIL midlw_memread: got %b want %b", obs_vec(), V_MEMRD);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({pc_write, ir_write, mem_write, reg_write, instr_done} !== 5'b0)
      $display("FAIL midlw_reset_strobes: got %b want 00000",
               {pc_write, ir_write, mem_write, reg_write, instr_done});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (obs_vec() !== V_FWAIT)
        $display("FAIL midlw_after_reset cycle %0d: got %b want %b", i, obs_vec(), V_FWAIT);
      else n_pass++;
      @(posedge clk); #1;
    end
    drive_instr(OP_ITP, 0, 0, rbit(), 0);
  endtask

  task automatic test_trap();
    drive_instr(OP_BAD, 1, 0, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = rbit(); zero = rbit();
      @(negedge clk);
      n_total++;
      if (obs_vec() !== V_IDLE) $display("FAIL trap_outputs cycle %0d: got %b want %b", i, obs_vec(), V_IDLE);
      else n_pass++;
      n_total++;
      if (illegal !== 1'b1) $display("FAIL trap_illegal cycle %0d: got %b want 1", i, illegal);
      else n_pass++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (illegal !== 1'b0) $display("FAIL trap_reset_illegal: got %b want 0", illegal);
    else n_pass++;
    n_total++;
    if (obs_vec() !== V_FWAIT) $display("FAIL trap_reset_fetch: got %b want %b", obs_vec(), V_FWAIT);
    else n_pass++;
    @(posedge clk); #1;
    drive_instr(OP_LUI, 0, 0, rbit(), 0);
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_jal_lui();
    test_random();
    test_reset_mid_lw();
    test_trap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
